wn_alu_pipe: RTL and testbench
==============================

Name: wn_alu_pipe

Overview:
- Parametrised, pipelined successor to the fixed 32-bit add/and/xor/not primitives.
- Single WIDTH-bit ALU with a runtime opcode, a running accumulator, and valid/ready handshakes on input and output.
- Two register stages, fully elastic under backpressure.
- Sits between ReWire-generated datapath logic and downstream consumers that may stall.

Parameters:
- WIDTH, 32: operand/result width in bits; legal range 1..64.
- ACC_INIT, 0: accumulator value after reset and after OP_ACCCLR; truncated to WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand/opcode valid
- in_ready  out  1  block can accept this cycle
- in_op  in  3  opcode (see Behaviour)
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B (ignored by NOT, ACCADD, ACCCLR)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  result
- out_carry  out  1  carry/borrow flag (only with WN_ALU_FLAGS_EN)
- out_zero  out  1  result==0 flag (only with WN_ALU_FLAGS_EN)

Behaviour:
- Opcodes:
  - 0 ADD: a+b mod 2^WIDTH
  - 1 SUB: a-b mod 2^WIDTH
  - 2 AND: a&b
  - 3 OR: a|b
  - 4 XOR: a^b
  - 5 NOT: ~a
  - 6 ACCADD: acc+a; acc updated to result
  - 7 ACCCLR: acc := ACC_INIT; result = old acc
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Stage S1 (capture):
  - Registers op, a, b and s1_valid on an input transfer.
  - in_ready = !s1_valid || s1_adv.
  - s1_adv = s1_valid && (!out_valid || out_ready).
- Stage S2 (compute/output):
  - On s1_adv, computes the result from S1 registers and loads out_data / out_valid = 1.
  - If out_ready && !s1_adv, out_valid clears.
- Latency: 2 cycles from input transfer to out_valid with no stall.
- Throughput: 1 result per cycle when out_ready is held high.
- in_ready is combinational from out_valid/out_ready; there is no combinational path from in_valid to out_*.
- Stall: while out_valid && !out_ready:
  - out_data and the flags are held stable.
  - S1 holds its contents.
  - in_ready = !s1_valid.
  - At most 2 items are in flight.
- Accumulator:
  - Updated only at the S1->S2 advance, in program order.
  - Back-to-back ACCADD operations chain correctly with no hazard.
  - Non-ACC ops never modify acc.
- Width rules:
  - All arithmetic wraps at WIDTH.
  - Carry for ADD/ACCADD = bit WIDTH of the (WIDTH+1)-bit sum.
  - Carry for SUB = borrow (1 when a<b unsigned).
- Reset (rst=1 at a clock edge):
  - s1_valid=0, out_valid=0, out_data=0, out_carry=0, out_zero=0, acc=ACC_INIT.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight items; no partial result is presented.
  - rst overrides simultaneous in_valid/out_ready.
- Simultaneous events:
  - Input transfer, S1 advance and output transfer may all occur in one cycle; no item is lost or duplicated.

Optional Feature:
- Macro: WN_ALU_FLAGS_EN.
- Defined:
  - out_carry and out_zero ports exist.
  - Both are registered in S2 alongside out_data, with the same valid/hold rules.
  - out_carry is 0 for logic ops and ACCCLR.
  - out_zero = (out_data==0).
- Undefined:
  - Both ports and their registers are absent.
  - Data path behaviour is otherwise identical.

Test Plan:
- Reset, WIDTH=32: after rst, in_ready=1, out_valid=0, out_data=0.
  - Then ADD a=0xFFFFFFFF, b=1 -> out_data=0x00000000 two cycles later; with flags enabled, carry=1, zero=1.
- Streaming: out_ready=1; ops SUB(5,7), AND(0xF0F0,0xFF00), OR(0xF0,0x0F), XOR(0xAA,0xFF), NOT(0) on consecutive cycles.
  - Results 0xFFFFFFFE (borrow=1), 0xF000, 0xFF, 0x55, 0xFFFFFFFF, one per cycle in order.
- Backpressure: send 3 items with out_ready=0.
  - in_ready drops after the 2nd accept; out_data is held.
  - Raise out_ready -> all 3 results delivered in order, no loss or duplication.
- Accumulator: ACCADD 3, ACCADD 4, ACCADD 5 back-to-back -> 3, 7, 12.
  - Then ACCCLR -> 12; then ACCADD 1 -> 1 (ACC_INIT=0).
- WIDTH=8, ACC_INIT=0xFE: ACCADD 3 -> 0x01, carry=1.
  - Assert rst mid-stall with out_valid=1 -> out_valid=0 next cycle and acc=0xFE.
- Simultaneous events: out_ready=1 and in_valid=1 held for 10 cycles -> in_ready=1 every cycle; 10 results.

Source files
------------

// File: rtl/wn_alu_pipe.sv
// wn_alu_pipe: two-stage elastic ALU with running accumulator.
// S1 captures opcode/operands; S2 computes and holds the result until the
// consumer accepts it. Optional macro WN_ALU_FLAGS_EN adds registered
// carry/borrow and zero flags (out_carry, out_zero).
module wn_alu_pipe #(
    parameter int          WIDTH    = 32,
    parameter logic [63:0] ACC_INIT = 64'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef WN_ALU_FLAGS_EN
    ,
    output logic             out_carry,
    output logic             out_zero
`endif
);

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_AND    = 3'd2,
        OP_OR     = 3'd3,
        OP_XOR    = 3'd4,
        OP_NOT    = 3'd5,
        OP_ACCADD = 3'd6,
        OP_ACCCLR = 3'd7
    } op_e;

    localparam logic [WIDTH-1:0] ACC_RST = ACC_INIT[WIDTH-1:0];

    // Arithmetic is one bit wider only when the carry flag needs bit WIDTH.
`ifdef WN_ALU_FLAGS_EN
    localparam int XW = WIDTH + 1;
`else
    localparam int XW = WIDTH;
`endif

    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH-1:0] acc;
    logic             s1_adv;

    logic [XW-1:0]    sum_add;
    logic [XW-1:0]    sum_sub;
    logic [XW-1:0]    sum_acc;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] acc_nxt;
    logic             acc_we;
`ifdef WN_ALU_FLAGS_EN
    logic             carry;
`endif

    assign s1_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s1_adv;

    // S1 capture register: loads on input transfer, empties when it advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= 3'd0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            s1_op    <= in_op;
            s1_a     <= in_a;
            s1_b     <= in_b;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Result, accumulator update and flags computed from the S1 contents.
    always_comb begin
        sum_add = XW'(s1_a) + XW'(s1_b);
        sum_sub = XW'(s1_a) - XW'(s1_b);
        sum_acc = XW'(acc) + XW'(s1_a);
        res     = '0;
        acc_nxt = acc;
        acc_we  = 1'b0;
`ifdef WN_ALU_FLAGS_EN
        carry   = 1'b0;
`endif
        case (op_e'(s1_op))
            OP_ADD: begin
                res = sum_add[WIDTH-1:0];
`ifdef WN_ALU_FLAGS_EN
                carry = sum_add[WIDTH];
`endif
            end
            OP_SUB: begin
                res = sum_sub[WIDTH-1:0];
`ifdef WN_ALU_FLAGS_EN
                carry = sum_sub[WIDTH];
`endif
            end
            OP_AND: res = s1_a & s1_b;
            OP_OR:  res = s1_a | s1_b;
            OP_XOR: res = s1_a ^ s1_b;
            OP_NOT: res = ~s1_a;
            OP_ACCADD: begin
                res     = sum_acc[WIDTH-1:0];
                acc_nxt = sum_acc[WIDTH-1:0];
                acc_we  = 1'b1;
`ifdef WN_ALU_FLAGS_EN
                carry = sum_acc[WIDTH];
`endif
            end
            OP_ACCCLR: begin
                res     = acc;
                acc_nxt = ACC_RST;
                acc_we  = 1'b1;
            end
            default: res = '0;
        endcase
    end

    // S2 output register and accumulator: load on advance, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            acc       <= ACC_RST;
`ifdef WN_ALU_FLAGS_EN
            out_carry <= 1'b0;
            out_zero  <= 1'b0;
`endif
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            out_data  <= res;
            if (acc_we) begin
                acc <= acc_nxt;
            end
`ifdef WN_ALU_FLAGS_EN
            out_carry <= carry;
            out_zero  <= (res == '0);
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wn_alu_pipe.sv
// Directed testbench for wn_alu_pipe (WIDTH=32/ACC_INIT=0 and WIDTH=8/ACC_INIT=0xFE).
module tb_wn_alu_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance signals
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_carry;
    logic        out_zero;

    // 8-bit instance signals
    logic        rst8 = 1'b1;
    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [2:0]  in_op8 = 3'd0;
    logic [7:0]  in_a8 = '0;
    logic [7:0]  in_b8 = '0;
    logic        out_valid8;
    logic        out_ready8 = 1'b0;
    logic [7:0]  out_data8;
    logic        out_carry8;
    logic        out_zero8;

    int tests = 0;
    int fails = 0;

    logic [31:0] q32[$];
    logic        qc32[$];
    logic [7:0]  q8[$];

    wn_alu_pipe #(.WIDTH(32), .ACC_INIT(64'd0)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef WN_ALU_FLAGS_EN
        , .out_carry(out_carry), .out_zero(out_zero)
`endif
    );

    wn_alu_pipe #(.WIDTH(8), .ACC_INIT(64'hFE)) dut8 (
        .clk(clk), .rst(rst8),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_op(in_op8),
        .in_a(in_a8), .in_b(in_b8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8)
`ifdef WN_ALU_FLAGS_EN
        , .out_carry(out_carry8), .out_zero(out_zero8)
`endif
    );

`ifndef WN_ALU_FLAGS_EN
    assign out_carry  = 1'b0;
    assign out_zero   = 1'b0;
    assign out_carry8 = 1'b0;
    assign out_zero8  = 1'b0;
`endif

    // Record every accepted output in arrival order.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) begin
            q32.push_back(out_data);
            qc32.push_back(out_carry);
        end
        if (!rst8 && out_valid8 && out_ready8) begin
            q8.push_back(out_data8);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic drain32(input int n);
        for (int k = 0; k < 20 && q32.size() < n; k++) step();
        tests++;
        if (q32.size() != n) begin
            fails++;
            $display("FAIL drain32 count: got %0d want %0d", q32.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        tests++;
        if (out_data !== 32'h0) begin fails++; $display("FAIL reset out_data: got %h want 0", out_data); end
        q32.delete(); qc32.delete();
        out_ready = 1'b1;
        drive(1'b1, 3'd0, 32'hFFFF_FFFF, 32'h1);
        step();
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL add latency1 out_valid: got %b want 0", out_valid); end
        step();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h0) begin
            fails++; $display("FAIL add wrap: got v=%b d=%h want v=1 d=00000000", out_valid, out_data);
        end
`ifdef WN_ALU_FLAGS_EN
        tests++;
        if (out_carry !== 1'b1 || out_zero !== 1'b1) begin
            fails++; $display("FAIL add flags: got c=%b z=%b want c=1 z=1", out_carry, out_zero);
        end
`endif
        step();
    endtask

    task automatic test_streaming();
        logic [2:0]  ops[5]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        logic [31:0] as[5]   = '{32'd5, 32'hF0F0, 32'hF0, 32'hAA, 32'h0};
        logic [31:0] bs[5]   = '{32'd7, 32'hFF00, 32'h0F, 32'hFF, 32'h0};
        logic [31:0] exp[5]  = '{32'hFFFF_FFFE, 32'hF000, 32'hFF, 32'h55, 32'hFFFF_FFFF};
        q32.delete(); qc32.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ops[i], as[i], bs[i]);
            step();
            if (i >= 1) begin
                tests++;
                if (out_valid !== 1'b1) begin fails++; $display("FAIL stream rate item %0d: out_valid=%b want 1", i, out_valid); end
            end
        end
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        drain32(5);
        for (int i = 0; i < 5 && i < q32.size(); i++) begin
            tests++;
            if (q32[i] !== exp[i]) begin fails++; $display("FAIL stream data %0d: got %h want %h", i, q32[i], exp[i]); end
        end
`ifdef WN_ALU_FLAGS_EN
        tests++;
        if (qc32.size() > 0 && qc32[0] !== 1'b1) begin fails++; $display("FAIL stream borrow: got %b want 1", qc32[0]); end
`endif
    endtask

    task automatic test_backpressure();
        logic [31:0] exp[3] = '{32'd3, 32'd30, 32'hE};
        q32.delete(); qc32.delete();
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 32'd1, 32'd2);
        step();
        drive(1'b1, 3'd0, 32'd10, 32'd20);
        step();
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL bp in_ready after 2nd: got %b want 0", in_ready); end
        drive(1'b1, 3'd4, 32'hF, 32'h1);
        for (int k = 0; k < 3; k++) begin
            step();
            tests++;
            if (out_valid !== 1'b1 || out_data !== 32'd3 || in_ready !== 1'b0) begin
                fails++; $display("FAIL bp hold cyc %0d: got v=%b d=%h rdy=%b want v=1 d=3 rdy=0", k, out_valid, out_data, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL bp release in_ready: got %b want 1", in_ready); end
        step();
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        drain32(3);
        step();
        step();
        tests++;
        if (q32.size() != 3) begin fails++; $display("FAIL bp duplicate: got %0d items want 3", q32.size()); end
        for (int i = 0; i < 3 && i < q32.size(); i++) begin
            tests++;
            if (q32[i] !== exp[i]) begin fails++; $display("FAIL bp data %0d: got %h want %h", i, q32[i], exp[i]); end
        end
    endtask

    task automatic test_accumulator();
        logic [2:0]  ops[5] = '{3'd6, 3'd6, 3'd6, 3'd7, 3'd6};
        logic [31:0] as[5]  = '{32'd3, 32'd4, 32'd5, 32'd99, 32'd1};
        logic [31:0] exp[5] = '{32'd3, 32'd7, 32'd12, 32'd12, 32'd1};
        q32.delete(); qc32.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ops[i], as[i], 32'hDEAD);
            step();
        end
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        drain32(5);
        for (int i = 0; i < 5 && i < q32.size(); i++) begin
            tests++;
            if (q32[i] !== exp[i]) begin fails++; $display("FAIL acc data %0d: got %h want %h", i, q32[i], exp[i]); end
        end
    endtask

    task automatic test_back_to_back();
        q32.delete(); qc32.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'd0, 32'(i), 32'd100);
            #1;
            tests++;
            if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b in_ready cyc %0d: got %b want 1", i, in_ready); end
            step();
        end
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        drain32(10);
        for (int i = 0; i < 10 && i < q32.size(); i++) begin
            tests++;
            if (q32[i] !== 32'(i + 100)) begin fails++; $display("FAIL b2b data %0d: got %h want %h", i, q32[i], 32'(i + 100)); end
        end
    endtask

    task automatic test_width8();
        rst8 = 1'b1;
        step();
        rst8 = 1'b0;
        q8.delete();
        out_ready8 = 1'b1;
        in_valid8 = 1'b1; in_op8 = 3'd6; in_a8 = 8'd3; in_b8 = 8'd0;
        step();
        in_valid8 = 1'b0;
        step();
        tests++;
        if (out_valid8 !== 1'b1 || out_data8 !== 8'h01) begin
            fails++; $display("FAIL w8 accadd: got v=%b d=%h want v=1 d=01", out_valid8, out_data8);
        end
`ifdef WN_ALU_FLAGS_EN
        tests++;
        if (out_carry8 !== 1'b1 || out_zero8 !== 1'b0) begin
            fails++; $display("FAIL w8 flags: got c=%b z=%b want c=1 z=0", out_carry8, out_zero8);
        end
`endif
        step();
        out_ready8 = 1'b0;
        in_valid8 = 1'b1; in_op8 = 3'd6; in_a8 = 8'd5;
        step();
        in_op8 = 3'd0; in_a8 = 8'd1; in_b8 = 8'd1;
        step();
        in_valid8 = 1'b0;
        tests++;
        if (out_valid8 !== 1'b1 || out_data8 !== 8'h06 || in_ready8 !== 1'b0) begin
            fails++; $display("FAIL w8 stall: got v=%b d=%h rdy=%b want v=1 d=06 rdy=0", out_valid8, out_data8, in_ready8);
        end
        rst8 = 1'b1;
        out_ready8 = 1'b1;
        step();
        rst8 = 1'b0;
        tests++;
        if (out_valid8 !== 1'b0 || out_data8 !== 8'h00 || in_ready8 !== 1'b1) begin
            fails++; $display("FAIL w8 midreset: got v=%b d=%h rdy=%b want v=0 d=00 rdy=1", out_valid8, out_data8, in_ready8);
        end
        q8.delete();
        in_valid8 = 1'b1; in_op8 = 3'd7; in_a8 = 8'd0; in_b8 = 8'd0;
        step();
        in_valid8 = 1'b0;
        for (int k = 0; k < 6; k++) step();
        tests++;
        if (q8.size() != 1) begin
            fails++; $display("FAIL w8 post-reset count: got %0d want 1", q8.size());
        end else begin
            tests++;
            if (q8[0] !== 8'hFE) begin fails++; $display("FAIL w8 acc after reset: got %h want fe", q8[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_accumulator();
        test_back_to_back();
        test_width8();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
